shake128_sponge_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one SHAKE128 sponge core between `NREQ` requesters. Requesters include the matrix-A row generators and the coin/seed expander. For each job the block:
- accepts one request (256-bit seed plus output length);
- loads and starts the sponge, waits for its `done` flag;
- returns the squeezed string on a valid/ready response channel;
- pulses the sponge reset to re-arm it, since the sponge holds `done` until reset.

---
 rtl/shake128_sponge_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_shake128_sponge_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shake128_sponge_arbiter.sv
// ---------------------------------------------------------------------------
// shake128_sponge_arbiter
//
// Shares one SHAKE128 sponge core between NREQ requesters (matrix-A row
// generators, coin/seed expander). Jobs are granted round-robin, one at a
// time: seed and length are loaded into the sponge, the sponge is started,
// its sticky done flag is awaited, the squeezed string is returned on a
// valid/ready channel, and the sponge is then reset to re-arm it.
//
// Optional feature macro: SPONGE_ARB_WDT_EN
//   When defined, a watchdog counts BUSY cycles. If WDT_CYCLES elapse
//   without sp_done, an all-zero response with rsp_err=1 is returned.
//   When undefined, BUSY waits indefinitely and rsp_err is tied to 0.
//
// Parameters:
//   NREQ        number of requesters (2..8)
//   OUT_W       squeezed output width in bits
//   WDT_CYCLES  watchdog limit in BUSY cycles (watchdog builds only)
//
// Ports:
//   clk, rst_n        clock; synchronous active-low reset
//   req_valid/ready   per-requester request handshake (ready is one-hot)
//   req_seed/req_len  per-requester 256-bit seed and 14-bit output length
//   rsp_valid/ready   response handshake
//   rsp_id/len/data   served requester, clamped length, masked output
//   rsp_err           watchdog abort flag
//   sp_*              sponge core control, payload and result
// ---------------------------------------------------------------------------
module shake128_sponge_arbiter #(
  parameter int NREQ       = 4,
  parameter int OUT_W      = 5376,
  parameter int WDT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*256-1:0]     req_seed,
  input  logic [NREQ*14-1:0]      req_len,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [13:0]             rsp_len,
  output logic [OUT_W-1:0]        rsp_data,
  output logic                    rsp_err,
  output logic                    sp_rst,
  output logic                    sp_enable,
  output logic [255:0]            sp_in,
  output logic [3:0]              sp_domain,
  output logic [13:0]             sp_output_len,
  input  logic [OUT_W-1:0]        sp_output_string,
  input  logic                    sp_done
);

  localparam int          ID_W    = $clog2(NREQ);
  localparam logic [13:0] MAX_LEN = 14'(OUT_W);

  localparam logic [2:0] S_CLEAR = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_BUSY  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]       state;
  logic [ID_W-1:0]  last_grant;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_found;
  logic [255:0]     gnt_seed;
  logic [13:0]      gnt_len_raw;
  logic [13:0]      gnt_len;
  logic [OUT_W-1:0] masked_out;
  logic             wdt_expire;
  int               cand;

  // Round-robin search starting just after last_grant. The loop walks the
  // candidates from farthest to nearest so the nearest asserted one wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = (int'(last_grant) + k) % NREQ;
      if (req_valid[ID_W'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(cand);
      end
    end
  end

  assign gnt_seed    = req_seed[int'(gnt_idx)*256 +: 256];
  assign gnt_len_raw = req_len[int'(gnt_idx)*14 +: 14];
  assign gnt_len     = (gnt_len_raw > MAX_LEN) ? MAX_LEN : gnt_len_raw;

  // Only the granted requester sees ready, and only while idle; a reset
  // cycle never accepts because the FSM is about to be forced to CLEAR.
  always_comb begin
    req_ready = '0;
    if ((state == S_IDLE) && rst_n && gnt_found)
      req_ready[gnt_idx] = 1'b1;
  end

  // Bits at or above the requested length are forced to zero so callers
  // never see squeeze output they did not ask for.
  always_comb begin
    masked_out = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (i < int'(sp_output_len))
        masked_out[i] = sp_output_string[i];
    end
  end

  // The sponge holds done until reset, so it is reset in CLEAR after every
  // job and also during the reset cycle itself.
  assign sp_rst    = !rst_n || (state == S_CLEAR);
  assign sp_enable = (state == S_START);
  assign sp_domain = 4'b1111;

  // Job sequencer: accept, start, wait for done, respond, re-arm.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_CLEAR;
      last_grant    <= ID_W'(NREQ - 1);
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_len       <= '0;
      rsp_data      <= '0;
      sp_in         <= '0;
      sp_output_len <= '0;
    end else begin
      case (state)
        S_CLEAR: state <= S_IDLE;
        S_IDLE: begin
          if (gnt_found) begin
            sp_in         <= gnt_seed;
            sp_output_len <= gnt_len;
            rsp_id        <= gnt_idx;
            last_grant    <= gnt_idx;
            state         <= S_START;
          end
        end
        S_START: state <= S_BUSY;
        S_BUSY: begin
          if (sp_done) begin
            rsp_data  <= masked_out;
            rsp_len   <= sp_output_len;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else if (wdt_expire) begin
            rsp_data  <= '0;
            rsp_len   <= sp_output_len;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_CLEAR;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

`ifdef SPONGE_ARB_WDT_EN
  localparam int CNT_W = $clog2(WDT_CYCLES + 1);

  logic [CNT_W-1:0] wdt_cnt;
  logic             err_q;

  assign wdt_expire = (state == S_BUSY) && (wdt_cnt == CNT_W'(WDT_CYCLES - 1));
  assign rsp_err    = err_q;

  // The counter is cleared in START so each job gets a full budget of BUSY
  // cycles; the error flag follows whichever response gets loaded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdt_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == S_START)
        wdt_cnt <= '0;
      else if ((state == S_BUSY) && !sp_done && !wdt_expire)
        wdt_cnt <= wdt_cnt + 1'b1;
      if (state == S_BUSY) begin
        if (sp_done)
          err_q <= 1'b0;
        else if (wdt_expire)
          err_q <= 1'b1;
      end
    end
  end
`else
  assign wdt_expire = 1'b0;
  assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_shake128_sponge_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shake128_sponge_arbiter
//
// Bench for shake128_sponge_arbiter. A behavioural sponge stand-in answers
// sp_enable after a random latency with a deterministic string derived from
// the seed and length it was given (including junk above the length). The
// expected responses come from a round-robin pick over the requester list
// and a length clamp/mask computed directly from the seed tables.
// Build with +define+SPONGE_ARB_WDT_EN to also exercise the watchdog.
// ---------------------------------------------------------------------------
module tb_shake128_sponge_arbiter;

  localparam int NREQ  = 4;
  localparam int OUT_W = 5376;
  localparam int WDT   = 50;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*256-1:0] req_seed;
  logic [NREQ*14-1:0]  req_len;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [1:0]          rsp_id;
  logic [13:0]         rsp_len;
  logic [OUT_W-1:0]    rsp_data;
  logic                rsp_err;
  logic                sp_rst;
  logic                sp_enable;
  logic [255:0]        sp_in;
  logic [3:0]          sp_domain;
  logic [13:0]         sp_output_len;
  logic [OUT_W-1:0]    sp_output_string = '0;
  logic                sp_done = 1'b0;

  logic [255:0] seed_tab [NREQ];
  logic [13:0]  len_tab  [NREQ];

  int n_cmp  = 0;
  int n_fail = 0;
  int model_last;

  // observations captured by run_job
  int               obs_gid;
  int               obs_wait;
  logic [NREQ-1:0]  obs_rdy;
  logic             obs_en;
  logic             obs_err;
  logic             obs_timeout;
  logic [255:0]     obs_sp_in;
  logic [13:0]      obs_sp_len;
  logic [13:0]      obs_len;
  logic [1:0]       obs_id;
  logic [OUT_W-1:0] obs_data;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_seed[g*256 +: 256] = seed_tab[g];
    assign req_len[g*14 +: 14]    = len_tab[g];
  end

  shake128_sponge_arbiter #(
    .NREQ(NREQ), .OUT_W(OUT_W), .WDT_CYCLES(WDT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_seed(req_seed), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_len(rsp_len), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .sp_rst(sp_rst), .sp_enable(sp_enable), .sp_in(sp_in), .sp_domain(sp_domain),
    .sp_output_len(sp_output_len), .sp_output_string(sp_output_string),
    .sp_done(sp_done)
  );

  function automatic logic [OUT_W-1:0] fake_sponge(logic [255:0] s, logic [13:0] l);
    logic [OUT_W-1:0] r;
    for (int k = 0; k < OUT_W/32; k++)
      r[k*32 +: 32] = s[(k%8)*32 +: 32] ^ (32'(k) * 32'h9E3779B9) ^ {18'd0, l};
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] len_mask(logic [13:0] l);
    logic [OUT_W-1:0] m;
    for (int i = 0; i < OUT_W; i++) m[i] = (i < int'(l));
    return m;
  endfunction

  function automatic logic [13:0] clamp(logic [13:0] l);
    return (int'(l) > OUT_W) ? 14'(OUT_W) : l;
  endfunction

  function automatic logic [OUT_W-1:0] exp_data(int id);
    return fake_sponge(seed_tab[id], clamp(len_tab[id])) & len_mask(clamp(len_tab[id]));
  endfunction

  function automatic int rr_pick(int last, logic [NREQ-1:0] m);
    for (int k = 1; k <= NREQ; k++)
      if (m[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic int first_diff(logic [OUT_W-1:0] a, logic [OUT_W-1:0] b);
    for (int i = 0; i < OUT_W; i++) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  // sponge stand-in: random latency, sticky done until sp_rst
  logic sponge_hang = 1'b0;
  logic sm_busy = 1'b0;
  int   sm_cnt = 0;
  logic [255:0] sm_seed;
  logic [13:0]  sm_len;

  always @(posedge clk) begin
    if (sp_rst) begin
      sp_done <= 1'b0;
      sm_busy <= 1'b0;
    end else if (sp_enable) begin
      sm_busy <= 1'b1;
      sm_cnt  <= $urandom_range(0, 10);
      sm_seed <= sp_in;
      sm_len  <= sp_output_len;
    end else if (sm_busy && !sponge_hang) begin
      if (sm_cnt == 0) begin
        sp_done          <= 1'b1;
        sp_output_string <= fake_sponge(sm_seed, sm_len);
        sm_busy          <= 1'b0;
      end else begin
        sm_cnt <= sm_cnt - 1;
      end
    end
  end

  // Drive one request set, wait for the grant and the response, then
  // complete the handshake (rsp_ready assumed high). Ends at the negedge
  // of the CLEAR cycle.
  task automatic run_job(input logic [NREQ-1:0] vmask);
    int w;
    obs_timeout = 1'b0;
    obs_gid     = -1;
    @(negedge clk);
    req_valid = vmask;
    #1;
    w = 0;
    while ((req_ready & req_valid) == '0 && w < 20) begin
      @(negedge clk); #1; w++;
    end
    if ((req_ready & req_valid) == '0) begin
      obs_timeout = 1'b1;
      req_valid   = '0;
      return;
    end
    obs_rdy = req_ready;
    for (int i = 0; i < NREQ; i++) if (req_ready[i] && req_valid[i]) obs_gid = i;
    @(negedge clk);
    req_valid = '0;
    #1;
    obs_en     = sp_enable;
    obs_sp_in  = sp_in;
    obs_sp_len = sp_output_len;
    w = 0;
    while (!rsp_valid && w < 300) begin
      @(negedge clk); #1; w++;
    end
    if (!rsp_valid) begin
      obs_timeout = 1'b1;
      return;
    end
    obs_wait = w;
    obs_id   = rsp_id;
    obs_len  = rsp_len;
    obs_data = rsp_data;
    obs_err  = rsp_err;
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (sp_rst !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_sp_rst: got %b want 1", sp_rst); end
    n_cmp++; if (req_ready !== '0) begin n_fail++; $display("[TB] FAIL reset_req_ready: got %b want 0", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if ({rsp_id, rsp_len, rsp_err} !== '0) begin n_fail++; $display("[TB] FAIL reset_rsp_fields: got id=%0d len=%0d err=%b want 0", rsp_id, rsp_len, rsp_err); end
    n_cmp++; if (rsp_data !== '0) begin n_fail++; $display("[TB] FAIL reset_rsp_data: first nonzero bit %0d", first_diff(rsp_data, '0)); end
    n_cmp++; if ({sp_enable, sp_output_len} !== '0) begin n_fail++; $display("[TB] FAIL reset_sp_ctrl: got en=%b len=%0d want 0", sp_enable, sp_output_len); end
    n_cmp++; if (sp_in !== '0) begin n_fail++; $display("[TB] FAIL reset_sp_in: got %h want 0", sp_in); end
    n_cmp++; if (sp_domain !== 4'b1111) begin n_fail++; $display("[TB] FAIL domain: got %b want 1111", sp_domain); end
    rst_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (sp_rst !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_release_sp_rst: got %b want 0", sp_rst); end
    model_last = NREQ - 1;
  endtask

  task automatic test_single();
    logic [OUT_W-1:0] e;
    seed_tab[0] = rand256();
    len_tab[0]  = 14'd1024;
    run_job(4'b0001);
    e = exp_data(0);
    n_cmp++; if (obs_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL single_timeout: got %b want 0", obs_timeout); end
    n_cmp++; if (obs_rdy !== 4'b0001) begin n_fail++; $display("[TB] FAIL single_ready: got %b want 0001", obs_rdy); end
    n_cmp++; if (obs_en !== 1'b1) begin n_fail++; $display("[TB] FAIL single_sp_enable: got %b want 1", obs_en); end
    n_cmp++; if (obs_sp_in !== seed_tab[0]) begin n_fail++; $display("[TB] FAIL single_sp_in: got %h want %h", obs_sp_in, seed_tab[0]); end
    n_cmp++; if (obs_sp_len !== 14'd1024) begin n_fail++; $display("[TB] FAIL single_sp_len: got %0d want 1024", obs_sp_len); end
    n_cmp++; if (obs_id !== 2'd0 || obs_len !== 14'd1024) begin n_fail++; $display("[TB] FAIL single_id_len: got id=%0d len=%0d want 0/1024", obs_id, obs_len); end
    n_cmp++; if (obs_data !== e) begin n_fail++; $display("[TB] FAIL single_data: first differing bit %0d", first_diff(obs_data, e)); end
    n_cmp++; if (obs_data[OUT_W-1:1024] !== '0) begin n_fail++; $display("[TB] FAIL single_upper_zero: upper bits nonzero, got low word %h want 0", obs_data[1055:1024]); end
    n_cmp++; if (sp_rst !== 1'b1) begin n_fail++; $display("[TB] FAIL single_rearm: got sp_rst=%b want 1", sp_rst); end
    @(negedge clk); #1;
    n_cmp++; if (sp_rst !== 1'b0) begin n_fail++; $display("[TB] FAIL single_rearm_once: got sp_rst=%b want 0", sp_rst); end
    model_last = 0;
  endtask

  task automatic test_round_robin();
    int exp_g;
    logic [OUT_W-1:0] e;
    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < NREQ; i++) begin
        seed_tab[i] = rand256();
        len_tab[i]  = 14'($urandom_range(0, 6000));
      end
      exp_g = rr_pick(model_last, 4'b1111);
      model_last = exp_g;
      run_job(4'b1111);
      e = exp_data(exp_g);
      n_cmp++; if (obs_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL rr_timeout job %0d: got %b want 0", j, obs_timeout); end
      n_cmp++; if (obs_gid != exp_g) begin n_fail++; $display("[TB] FAIL rr_grant job %0d: got %0d want %0d", j, obs_gid, exp_g); end
      n_cmp++; if ($countones(obs_rdy) != 1) begin n_fail++; $display("[TB] FAIL rr_onehot job %0d: got %b want one bit", j, obs_rdy); end
      n_cmp++; if (obs_id !== 2'(exp_g) || obs_len !== clamp(len_tab[exp_g])) begin n_fail++; $display("[TB] FAIL rr_id_len job %0d: got %0d/%0d want %0d/%0d", j, obs_id, obs_len, exp_g, clamp(len_tab[exp_g])); end
      n_cmp++; if (obs_data !== e) begin n_fail++; $display("[TB] FAIL rr_data job %0d: first differing bit %0d", j, first_diff(obs_data, e)); end
    end
  endtask

  task automatic test_len_bounds();
    int ids [4] = '{2, 3, 0, 1};
    int lens [4] = '{6000, 0, 5376, 5377};
    int id;
    logic [OUT_W-1:0] e;
    for (int c = 0; c < 4; c++) begin
      id = ids[c];
      seed_tab[id] = rand256();
      len_tab[id]  = 14'(lens[c]);
      model_last = rr_pick(model_last, 4'(1 << id));
      run_job(4'(1 << id));
      e = exp_data(id);
      n_cmp++; if (obs_timeout !== 1'b0 || obs_gid != id) begin n_fail++; $display("[TB] FAIL len_grant case %0d: got gid %0d timeout %b want %0d", c, obs_gid, obs_timeout, id); end
      n_cmp++; if (obs_sp_len !== clamp(14'(lens[c]))) begin n_fail++; $display("[TB] FAIL len_sp_len case %0d: got %0d want %0d", c, obs_sp_len, clamp(14'(lens[c]))); end
      n_cmp++; if (obs_len !== clamp(14'(lens[c]))) begin n_fail++; $display("[TB] FAIL len_rsp_len case %0d: got %0d want %0d", c, obs_len, clamp(14'(lens[c]))); end
      n_cmp++; if (obs_data !== e) begin n_fail++; $display("[TB] FAIL len_data case %0d: first differing bit %0d", c, first_diff(obs_data, e)); end
    end
  endtask

  task automatic test_stall();
    int w;
    logic [OUT_W-1:0] e;
    seed_tab[0] = rand256();
    len_tab[0]  = 14'($urandom_range(1, 5376));
    seed_tab[1] = rand256();
    len_tab[1]  = 14'($urandom_range(1, 5376));
    e = exp_data(0);
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 4'b0001;
    #1;
    w = 0;
    while (req_ready[0] !== 1'b1 && w < 20) begin @(negedge clk); #1; w++; end
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    w = 0;
    while (!rsp_valid && w < 300) begin @(negedge clk); #1; w++; end
    n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_rsp_timeout: got rsp_valid %b want 1", rsp_valid); end
    for (int c = 0; c < 10; c++) begin
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_len !== len_tab[0] || rsp_data !== e || req_ready !== '0) begin
        n_fail++;
        $display("[TB] FAIL stall_hold cycle %0d: got v=%b id=%0d len=%0d ready=%b datadiff=%0d want 1/0/%0d/0000/-1",
                 c, rsp_valid, rsp_id, rsp_len, req_ready, first_diff(rsp_data, e), len_tab[0]);
      end
      @(negedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== '0) begin n_fail++; $display("[TB] FAIL stall_clear: got v=%b ready=%b want 0/0000", rsp_valid, req_ready); end
    @(negedge clk); #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("[TB] FAIL stall_next_accept: got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    w = 0;
    while (!rsp_valid && w < 300) begin @(negedge clk); #1; w++; end
    e = exp_data(1);
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== e) begin n_fail++; $display("[TB] FAIL stall_second: got v=%b id=%0d datadiff=%0d want 1/1/-1", rsp_valid, rsp_id, first_diff(rsp_data, e)); end
    @(negedge clk); #1;
    model_last = 1;
  endtask

  task automatic test_reset_mid_busy();
    int w;
    int seen;
    seed_tab[2] = rand256();
    len_tab[2]  = 14'd512;
    sponge_hang = 1'b1;
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    w = 0;
    while (req_ready[2] !== 1'b1 && w < 20) begin @(negedge clk); #1; w++; end
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (sp_rst !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_sp_rst_first: got %b want 1", sp_rst); end
    @(negedge clk); #1;
    n_cmp++; if (sp_rst !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_sp_rst_second: got %b want 1", sp_rst); end
    n_cmp++; if ({req_ready, rsp_valid, rsp_id, rsp_len, rsp_err, sp_enable, sp_output_len} !== '0 || sp_in !== '0 || rsp_data !== '0) begin
      n_fail++;
      $display("[TB] FAIL midrst_outputs: got ready=%b v=%b id=%0d len=%0d err=%b en=%b splen=%0d want all 0", req_ready, rsp_valid, rsp_id, rsp_len, rsp_err, sp_enable, sp_output_len);
    end
    rst_n = 1'b1;
    sponge_hang = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (sp_rst !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_sp_rst_third: got %b want 0", sp_rst); end
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid === 1'b1) seen++;
      @(negedge clk); #1;
    end
    n_cmp++; if (seen != 0) begin n_fail++; $display("[TB] FAIL midrst_no_response: got %0d valid cycles want 0", seen); end
    model_last = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin
      seed_tab[i] = rand256();
      len_tab[i]  = 14'($urandom_range(0, 5376));
    end
    run_job(4'b1111);
    n_cmp++; if (obs_timeout !== 1'b0 || obs_gid != rr_pick(model_last, 4'b1111)) begin n_fail++; $display("[TB] FAIL midrst_next_grant: got %0d want %0d", obs_gid, rr_pick(model_last, 4'b1111)); end
    model_last = 0;
  endtask

`ifdef SPONGE_ARB_WDT_EN
  task automatic test_wdt();
    logic [OUT_W-1:0] e;
    seed_tab[2] = rand256();
    len_tab[2]  = 14'($urandom_range(1, 5376));
    sponge_hang = 1'b1;
    run_job(4'b0100);
    sponge_hang = 1'b0;
    n_cmp++; if (obs_timeout !== 1'b0) begin n_fail++; $display("[TB] FAIL wdt_timeout: got %b want 0", obs_timeout); end
    n_cmp++; if (obs_wait != WDT + 1) begin n_fail++; $display("[TB] FAIL wdt_latency: got %0d want %0d", obs_wait, WDT + 1); end
    n_cmp++; if (obs_err !== 1'b1 || obs_data !== '0) begin n_fail++; $display("[TB] FAIL wdt_abort: got err=%b datadiff=%0d want 1/-1", obs_err, first_diff(obs_data, '0)); end
    n_cmp++; if (obs_id !== 2'd2 || obs_len !== len_tab[2]) begin n_fail++; $display("[TB] FAIL wdt_id_len: got %0d/%0d want 2/%0d", obs_id, obs_len, len_tab[2]); end
    seed_tab[3] = rand256();
    len_tab[3]  = 14'($urandom_range(1, 5376));
    run_job(4'b1000);
    e = exp_data(3);
    n_cmp++; if (obs_err !== 1'b0 || obs_data !== e) begin n_fail++; $display("[TB] FAIL wdt_recover: got err=%b datadiff=%0d want 0/-1", obs_err, first_diff(obs_data, e)); end
    model_last = 3;
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      seed_tab[i] = '0;
      len_tab[i]  = '0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_len_bounds();
    test_stall();
    test_reset_mid_busy();
`ifdef SPONGE_ARB_WDT_EN
    test_wdt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not complete, got no end want end");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
